// File: rtl/prog_mem.sv
// Synchronous-read program memory with a registered fetch port and a
// byte-serial run-time loader; fetch is only served while the loader is idle.
module prog_mem #(
  parameter  int DATA_WIDTH     = 24,
  parameter  int ADDR_BITS      = 4,
  localparam int BYTES_PER_WORD = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  // Fetch port
  input  logic                  rd_en,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,

  // Byte-serial loader
  input  logic                  load_start,
  input  logic [ADDR_BITS-1:0]  load_base,
  input  logic [ADDR_BITS:0]    load_len,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  output logic                  load_busy,
  output logic                  load_done
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int CNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [CNT_W-1:0]     LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE   = ADDR_BITS'(1);
  localparam logic [ADDR_BITS:0]   REM_ONE   = (ADDR_BITS + 1)'(1);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_BITS-1:0]  ptr;
  logic [ADDR_BITS:0]    remaining;
  logic [CNT_W-1:0]      byte_cnt;
  logic [DATA_WIDTH-1:0] asm_q;
  logic [DATA_WIDTH-1:0] asm_nxt;

  logic accept_rd;
  logic start_load;
  logic start_empty;
  logic byte_fire;
  logic word_done;
  logic last_word;

  // Power-up contents are NOP; the array itself is never touched by reset.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default assignment first so that no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    accept_rd   = 1'b0;
    start_load  = 1'b0;
    start_empty = 1'b0;
    byte_fire   = 1'b0;
    if (state == IDLE) begin
      accept_rd   = rd_en;
      start_load  = load_start && (load_len != '0);
      start_empty = load_start && (load_len == '0);
    end else begin
      byte_fire = load_valid;
    end
  end

  // Shifting the new byte in at the bottom and truncating to DATA_WIDTH drops
  // both stale bits of the previous word and the excess top bits of byte 0.
  assign asm_nxt   = DATA_WIDTH'({asm_q, load_byte});
  assign word_done = byte_fire && (byte_cnt == LAST_BYTE);
  assign last_word = word_done && (remaining == REM_ONE);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_load) state_nxt = LOAD;
      LOAD: if (last_word)  state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    rd_ready  = 1'b0;
    load_busy = 1'b0;
    unique case (state)
      IDLE:    rd_ready  = 1'b1;
      LOAD:    load_busy = 1'b1;
      default: rd_ready  = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Fetch port and completion pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      load_done <= 1'b0;
    end else begin
      rd_valid  <= accept_rd;
      load_done <= start_empty || last_word;
      if (accept_rd) rd_data <= mem[rd_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Loader pointers and word assembly
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      remaining <= '0;
      byte_cnt  <= '0;
      asm_q     <= '0;
    end else if (start_load) begin
      ptr       <= load_base;
      remaining <= load_len;
      byte_cnt  <= '0;
    end else if (byte_fire) begin
      asm_q <= asm_nxt;
      if (word_done) begin
        byte_cnt  <= '0;
        ptr       <= ptr + PTR_ONE;
        remaining <= remaining - REM_ONE;
      end else begin
        byte_cnt <= byte_cnt + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the memory array has no reset branch so it maps onto RAM; gating the
  // write with !rst keeps a reset coincident with the final byte from landing.
  always_ff @(posedge clk) begin
    if (word_done && !rst) mem[ptr] <= asm_nxt;
  end

endmodule
